cmd_burst_bram: RTL and testbench

- Parametrised successor to the combinational command/matrix memory used by the graphics command front end.
- Provides a synchronous single-word fetch port (command stream) and a burst read port. The burst port gathers BURST_LEN consecutive words (matrix rows/columns) over successive cycles and presents them packed, under a valid/ack handshake.
- Adds a byte-enabled write port so the host can load command and matrix data at run time.

---
 rtl/cmd_burst_bram.sv | 105 ++++++++++
 tb/tb_cmd_burst_bram.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_burst_bram.sv
// cmd_burst_bram: command/matrix memory with a single-word fetch port, a packed burst read port and a byte-enabled write port
module cmd_burst_bram #(
    parameter int DEPTH     = 64,
    parameter int ADDR_W    = 6,
    parameter int BURST_LEN = 4,
    parameter     INIT_FILE = ""
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ia_en,
    input  logic [31:0]            ia_addr,
    output logic [31:0]            ia_data,
    output logic                   ia_valid,
    input  logic                   bw_req,
    input  logic [31:0]            bw_addr,
    output logic                   bw_busy,
    output logic                   bw_valid,
    input  logic                   bw_ack,
    output logic [32*BURST_LEN-1:0] bw_data,
    input  logic                   wr_en,
    input  logic [31:0]            wr_addr,
    input  logic [31:0]            wr_data,
    input  logic [3:0]             wr_be
);
    localparam int CNT_W = $clog2(BURST_LEN) + 1;

    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    logic [31:0]       mem [DEPTH];
    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] ia_idx;
    logic [ADDR_W-1:0] bw_idx;
    logic [ADDR_W-1:0] wr_idx;
    logic [ADDR_W-1:0] rd_idx;
    logic [31:0]       rd_word;
    logic              unused_addr_bits;

    assign ia_idx = ia_addr[ADDR_W+1:2];
    assign bw_idx = bw_addr[ADDR_W+1:2];
    assign wr_idx = wr_addr[ADDR_W+1:2];
    // Index arithmetic is ADDR_W wide so a burst past DEPTH-1 wraps to 0
    assign rd_idx = base + ADDR_W'(cnt);
    assign unused_addr_bits = ^{ia_addr[31:ADDR_W+2], ia_addr[1:0],
                                bw_addr[31:ADDR_W+2], bw_addr[1:0],
                                wr_addr[31:ADDR_W+2], wr_addr[1:0]};

    // Byte-enabled write; no reset so contents survive rst
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (wr_en && wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
    end

    // Fetch port: one-cycle synchronous read, data held while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ia_data  <= '0;
            ia_valid <= 1'b0;
        end else begin
            ia_valid <= ia_en;
            if (ia_en) ia_data <= mem[ia_idx];
        end
    end

    // Burst engine: issue one read per cycle, land each word in its lane an edge later, then hold until ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            base     <= '0;
            rd_word  <= '0;
            bw_data  <= '0;
            bw_valid <= 1'b0;
            bw_busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bw_req) begin
                    base    <= bw_idx;
                    cnt     <= '0;
                    bw_busy <= 1'b1;
                    state   <= FETCH;
                end
                FETCH: begin
                    for (int k = 0; k < BURST_LEN; k++)
                        if (cnt == CNT_W'(k + 1)) bw_data[32*k +: 32] <= rd_word;
                    if (cnt == CNT_W'(BURST_LEN)) begin
                        cnt      <= '0;
                        bw_valid <= 1'b1;
                        state    <= HOLD;
                    end else begin
                        rd_word <= mem[rd_idx];
                        cnt     <= cnt + 1'b1;
                    end
                end
                HOLD: if (bw_ack) begin
                    bw_valid <= 1'b0;
                    bw_busy  <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cmd_burst_bram.sv
// tb_cmd_burst_bram: directed stimulus checked every cycle against a timeline model of the memory
module tb_cmd_burst_bram;
    localparam int D  = 64;
    localparam int AW = 6;
    localparam int BL = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ia_en = 1'b0;
    logic [31:0]     ia_addr = '0;
    logic [31:0]     ia_data;
    logic            ia_valid;
    logic            bw_req = 1'b0;
    logic [31:0]     bw_addr = '0;
    logic            bw_busy;
    logic            bw_valid;
    logic            bw_ack = 1'b0;
    logic [32*BL-1:0] bw_data;
    logic            wr_en = 1'b0;
    logic [31:0]     wr_addr = '0;
    logic [31:0]     wr_data = '0;
    logic [3:0]      wr_be = '0;

    int n_chk = 0;
    int n_fail = 0;

    cmd_burst_bram #(.DEPTH(D), .ADDR_W(AW), .BURST_LEN(BL), .INIT_FILE("")) dut (
        .clk(clk), .rst(rst),
        .ia_en(ia_en), .ia_addr(ia_addr), .ia_data(ia_data), .ia_valid(ia_valid),
        .bw_req(bw_req), .bw_addr(bw_addr), .bw_busy(bw_busy), .bw_valid(bw_valid),
        .bw_ack(bw_ack), .bw_data(bw_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: a burst accepted at edge t0 snapshots word k at edge t0+1+k (before that edge's write) and presents all lanes from edge t0+BL+1
    logic [31:0]      m_mem [D];
    logic [31:0]      m_snap [BL];
    logic [31:0]      m_ia_data = '0;
    logic             m_ia_valid = 1'b0;
    logic             m_busy = 1'b0;
    logic             m_valid = 1'b0;
    logic [32*BL-1:0] m_bw_data = '0;
    int               m_base = 0;
    int               cyc = 0;
    int               t0 = 0;
    int               mk = 0;
    int               m_windows = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ia_data = '0;
            m_ia_valid = 1'b0;
            m_busy = 1'b0;
            m_valid = 1'b0;
            m_bw_data = '0;
        end else begin
            cyc++;
            m_ia_valid = ia_en;
            if (ia_en) m_ia_data = m_mem[ia_addr[AW+1:2]];
            if (!m_busy) begin
                if (bw_req) begin
                    m_busy = 1'b1;
                    m_base = int'(bw_addr[AW+1:2]);
                    t0 = cyc;
                end
            end else if (!m_valid) begin
                mk = cyc - t0 - 1;
                if (mk >= 0 && mk < BL) m_snap[mk] = m_mem[(m_base + mk) % D];
                if (cyc - t0 == BL + 1) begin
                    m_valid = 1'b1;
                    m_windows++;
                    for (int j = 0; j < BL; j++) m_bw_data[32*j +: 32] = m_snap[j];
                end
            end else if (bw_ack) begin
                m_busy = 1'b0;
                m_valid = 1'b0;
            end
            if (wr_en)
                for (int b = 0; b < 4; b++)
                    if (wr_be[b]) m_mem[wr_addr[AW+1:2]][8*b +: 8] = wr_data[8*b +: 8];
        end
    end

    // Compare process on the falling edge
    logic prev_v = 1'b0;
    int   windows = 0;
    always @(negedge clk) begin
        chk("ia_valid", ia_valid, m_ia_valid);
        chk("ia_data", ia_data, m_ia_data);
        chk("bw_busy", bw_busy, m_busy);
        chk("bw_valid", bw_valid, m_valid);
        if (m_valid || !m_busy) chk("bw_data", bw_data, m_bw_data);
        if (bw_valid && !prev_v) windows++;
        prev_v = bw_valid;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
        step();
        wr_en = 1'b0; wr_be = '0;
    endtask

    task automatic fetch(input logic [31:0] a);
        ia_en = 1'b1; ia_addr = a;
        step();
        ia_en = 1'b0;
    endtask

    task automatic start_burst(input logic [31:0] a);
        bw_req = 1'b1; bw_addr = a;
        step();
        bw_req = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!bw_valid && n < 20) begin
            step();
            n++;
        end
        chk("wait_valid", bw_valid, 1'b1);
    endtask

    task automatic ack();
        bw_ack = 1'b1;
        step();
        bw_ack = 1'b0;
        chk("ack_valid_drop", bw_valid, 1'b0);
        chk("ack_busy_drop", bw_busy, 1'b0);
    endtask

    initial begin
        repeat (3) step();
        chk("rst_ia_valid", ia_valid, 1'b0);
        chk("rst_bw_data", bw_data, '0);
        rst = 1'b0;
        for (int i = 0; i < D; i++) wr(32'(i * 4), 32'hA5A50000 | 32'(i), 4'hF);

        // Fetch after write, aligned and unaligned byte address
        wr(32'h8, 32'h80001013, 4'hF);
        fetch(32'h8);
        chk("fetch_valid", ia_valid, 1'b1);
        chk("fetch_data", ia_data, 32'h80001013);
        fetch(32'hB);
        chk("fetch_unaligned", ia_data, 32'h80001013);
        step();
        chk("fetch_idle_valid", ia_valid, 1'b0);
        chk("fetch_hold_data", ia_data, 32'h80001013);

        // Basic burst with latency and hold
        wr(32'hC, 32'h42013333, 4'hF);
        wr(32'h10, 32'h42C8A666, 4'hF);
        wr(32'h14, 32'h44A72000, 4'hF);
        wr(32'h18, 32'h3F800000, 4'hF);
        start_burst(32'hC);
        chk("busy_next", bw_busy, 1'b1);
        repeat (BL) step();
        chk("valid_not_early", bw_valid, 1'b0);
        step();
        chk("valid_edge5", bw_valid, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("burst_lanes", bw_data, {32'h3F800000, 32'h44A72000, 32'h42C8A666, 32'h42013333});
            step();
        end
        ack();
        chk("data_kept", bw_data, {32'h3F800000, 32'h44A72000, 32'h42C8A666, 32'h42013333});

        // Wrap across DEPTH-1
        start_burst(32'hF8);
        wait_valid();
        chk("wrap_lanes", bw_data, {32'hA5A50001, 32'hA5A50000, 32'hA5A5003F, 32'hA5A5003E});
        ack();

        // Same-cycle write (old data) and earlier write (new data)
        start_burst(32'hC);
        step();
        wr_en = 1'b1; wr_addr = 32'h10; wr_data = 32'h11111111; wr_be = 4'hF;
        step();
        wr_addr = 32'h18; wr_data = 32'hCAFEF00D;
        ia_en = 1'b1; ia_addr = 32'h10;
        step();
        wr_en = 1'b0; wr_be = '0; ia_en = 1'b0;
        chk("fetch_during_burst", ia_data, 32'h11111111);
        step();
        step();
        chk("collide_lanes", bw_data, {32'hCAFEF00D, 32'h44A72000, 32'h42C8A666, 32'h42013333});
        ack();

        // Partial byte write
        wr(32'h20, 32'h00000000, 4'hF);
        wr(32'h20, 32'hFFFFFFFF, 4'h3);
        wr(32'h20, 32'h12345678, 4'h0);
        fetch(32'h20);
        chk("partial_write", ia_data, 32'h0000FFFF);

        // req held through FETCH and HOLD, ack outside HOLD: one window only
        bw_req = 1'b1; bw_addr = 32'h40;
        step();
        bw_ack = 1'b1;
        step();
        step();
        bw_ack = 1'b0;
        repeat (5) step();
        chk("held_req_valid", bw_valid, 1'b1);
        bw_req = 1'b0;
        ack();
        repeat (3) step();
        chk("one_window", windows, 4);

        // Reset mid-FETCH with cnt=2
        start_burst(32'hC);
        step();
        step();
        rst = 1'b1;
        #1;
        chk("rst_busy", bw_busy, 1'b0);
        chk("rst_valid", bw_valid, 1'b0);
        chk("rst_data", bw_data, '0);
        chk("rst_ia_data", ia_data, '0);
        step();
        step();
        rst = 1'b0;
        repeat (8) step();
        chk("no_valid_after_abort", windows, 4);
        start_burst(32'hC);
        repeat (BL + 1) step();
        chk("post_rst_lanes", bw_data, {32'hCAFEF00D, 32'h44A72000, 32'h11111111, 32'h42013333});
        ack();
        step();
        chk("windows_model", windows, m_windows);
        chk("windows_total", windows, 5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
